// File: rtl/tbs_pkg.sv
// tbs_pkg: shared types and constants for the tracking-threshold sampler board.
package tbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_SAMPLE    = 2'd3
  } tbs_state_t;

  localparam int unsigned ATBS_STEP_CAP = 64;
  // 8 MHz / 69 ~= 115200 baud
  localparam int unsigned UART_DIV      = 69;

endpackage

// File: rtl/tbs_debouncer.sv
// tbs_debouncer: 2-FF synchroniser plus inversion of an active-low switch;
// a new level is accepted only after it has been stable for CYCLES clocks.
module tbs_debouncer
  import tbs_pkg::*;
#(
  parameter int unsigned CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw_n,
  output logic o_level
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          w_raw;

  assign w_raw = ~r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '1;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_sw_n};
      if (w_raw == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 1)) begin
        r_level <= w_raw;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/tbs_core_board.sv
// tbs_core_board: tracking-threshold (TBS/ATBS) level-crossing sampler board core.
// Optional build macro UART_TX_EN adds an 8N1 threshold-update stream on uart_tx_o.
module tbs_core_board
  import tbs_pkg::*;
#(
  parameter int unsigned DAC_BITWIDTH      = 10,
  parameter int unsigned DAC_SETTLING_CLKS = 80,
  parameter int unsigned DEBOUNCE_CYCLES   = 65536,
  parameter int unsigned TBS_WINDOW        = 16,
  parameter int unsigned VIRT_DELTA        = 8
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    comp_upper_i,
  input  logic                    comp_lower_i,
  input  logic                    trigger_start_sampling_i,
  input  logic                    trigger_start_mode_i,
  input  logic                    adaptive_mode_i,
  input  logic                    control_mode_i,
  input  logic                    signal_select_in_i,
  input  logic                    enable_i,
  input  logic                    select_tbs_delta_steps_i,
  input  logic                    ecg_lod_p_i,
  input  logic                    ecg_lod_n_i,
  input  logic                    uart_rx_i,
  output logic                    signal_select_en_o,
  output logic                    signal_select_in_o,
  output logic                    amp_sdn_o,
  output logic                    dac_pd_o,
  output logic                    dac_clr_o,
  output logic                    dac_wr_upper_o,
  output logic                    dac_wr_lower_o,
  output logic [DAC_BITWIDTH-1:0] dac_upper_o,
  output logic [DAC_BITWIDTH-1:0] dac_lower_o,
  output logic                    dac_pwm_upper_o,
  output logic                    dac_pwm_lower_o,
  output logic                    idle_led_o,
  output logic                    overflow_led_o,
  output logic                    underflow_led_o,
  output logic                    ecg_led_o,
  output logic                    analog_trigger_o,
  output logic                    sc_noc_1_o,
  output logic                    sc_noc_2_o,
  output logic                    uart_tx_o
);

  localparam int unsigned N   = DAC_BITWIDTH;
  localparam int unsigned NW  = N + 1;
  localparam int unsigned SCW = $clog2(DAC_SETTLING_CLKS + 1);

  localparam logic [N-1:0]  MID        = N'(1 << (N - 1));
  localparam logic [N-1:0]  UPPER_INIT = MID + N'(TBS_WINDOW);
  localparam logic [N-1:0]  LOWER_INIT = MID - N'(TBS_WINDOW);
  localparam logic [NW-1:0] CODE_MAX   = {1'b0, {N{1'b1}}};
  localparam logic [NW-1:0] STEP_CAP   = NW'(ATBS_STEP_CAP);

  // Switch bits: 0 trigger mode, 1 adaptive, 2 control, 3 signal select, 4 enable, 5 delta
  logic [5:0] w_sw_raw, w_sw, r_sw_prev;
  logic       w_trig_mode, w_adaptive, w_ctrl, w_sel, w_enable, w_delta, w_cfg_change;

  assign w_sw_raw = {select_tbs_delta_steps_i, enable_i, signal_select_in_i,
                     control_mode_i, adaptive_mode_i, trigger_start_mode_i};

  for (genvar g = 0; g < 6; g++) begin : g_deb
    tbs_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clock_i),
      .rst    (reset_i),
      .i_sw_n (w_sw_raw[g]),
      .o_level(w_sw[g])
    );
  end

  assign w_trig_mode  = w_sw[0];
  assign w_adaptive   = w_sw[1];
  assign w_ctrl       = w_sw[2];
  assign w_sel        = w_sw[3];
  assign w_enable     = w_sw[4];
  assign w_delta      = w_sw[5];
  assign w_cfg_change = |((w_sw ^ r_sw_prev) & 6'b101011);

  logic [1:0] r_cu_sync, r_cl_sync, r_trig_sync;
  logic       r_trig_prev, w_cu, w_cl, w_trig_rise;

  assign w_cu        = r_cu_sync[1];
  assign w_cl        = r_cl_sync[1];
  assign w_trig_rise = r_trig_sync[1] & ~r_trig_prev;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_cu_sync   <= '0;
      r_cl_sync   <= '1;
      r_trig_sync <= '0;
      r_trig_prev <= 1'b0;
      r_sw_prev   <= '0;
    end else begin
      r_cu_sync   <= {r_cu_sync[0], comp_upper_i};
      r_cl_sync   <= {r_cl_sync[0], comp_lower_i};
      r_trig_sync <= {r_trig_sync[0], trigger_start_sampling_i};
      r_trig_prev <= r_trig_sync[1];
      r_sw_prev   <= w_sw;
    end
  end

  tbs_state_t     r_state, w_next;
  logic [SCW-1:0] r_settle_cnt;
  logic [N-1:0]   r_upper, r_lower, w_upper_nxt, w_lower_nxt;
  logic [NW-1:0]  r_step, w_atbs_step, w_step;
  logic           r_dir_valid, r_dir_up, r_ovf, r_unf, r_wr;
  logic           w_event, w_ovf_set, w_unf_set;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Config changes and enable loss override whatever the state itself would do.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_enable) w_next = ST_WAIT_TRIG;
      ST_WAIT_TRIG: if (!w_trig_mode || w_trig_rise) w_next = ST_SETTLE;
      ST_SETTLE:    if (r_settle_cnt == SCW'(DAC_SETTLING_CLKS)) w_next = ST_SAMPLE;
      ST_SAMPLE:    if (w_cu || !w_cl) w_next = ST_SETTLE;
      default:      w_next = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && w_cfg_change) w_next = ST_WAIT_TRIG;
    if (!w_enable) w_next = ST_IDLE;
  end

  assign w_event = (r_state == ST_SAMPLE) && (w_next == ST_SETTLE);

  always_comb begin
    w_atbs_step = NW'(1);
    if (r_dir_valid && (r_dir_up == w_cu))
      w_atbs_step = (r_step >= (STEP_CAP >> 1)) ? STEP_CAP : (r_step << 1);
    if (w_adaptive)   w_step = w_atbs_step;
    else if (w_delta) w_step = NW'(VIRT_DELTA);
    else              w_step = NW'(1);
  end

  always_comb begin
    w_upper_nxt = r_upper;
    w_lower_nxt = r_lower;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (w_cu) begin
      if (({1'b0, r_upper} + w_step) <= CODE_MAX) begin
        w_upper_nxt = r_upper + w_step[N-1:0];
        w_lower_nxt = r_lower + w_step[N-1:0];
      end else begin
        w_ovf_set = 1'b1;
      end
    end else begin
      if ({1'b0, r_lower} >= w_step) begin
        w_upper_nxt = r_upper - w_step[N-1:0];
        w_lower_nxt = r_lower - w_step[N-1:0];
      end else begin
        w_unf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_upper      <= UPPER_INIT;
      r_lower      <= LOWER_INIT;
      r_step       <= NW'(1);
      r_dir_valid  <= 1'b0;
      r_dir_up     <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_wr         <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      r_wr         <= (w_next == ST_SETTLE) && (r_state != ST_SETTLE);
      r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + 1'b1 : '0;
      if (w_next == ST_WAIT_TRIG) begin
        r_upper     <= UPPER_INIT;
        r_lower     <= LOWER_INIT;
        r_ovf       <= 1'b0;
        r_unf       <= 1'b0;
        r_step      <= NW'(1);
        r_dir_valid <= 1'b0;
      end else if (w_event) begin
        r_upper     <= w_upper_nxt;
        r_lower     <= w_lower_nxt;
        r_ovf       <= r_ovf | w_ovf_set;
        r_unf       <= r_unf | w_unf_set;
        r_step      <= w_atbs_step;
        r_dir_up    <= w_cu;
        r_dir_valid <= 1'b1;
      end else if (r_state == ST_SAMPLE && w_next == ST_SAMPLE) begin
        r_step      <= NW'(1);
        r_dir_valid <= 1'b0;
      end
    end
  end

  logic [N-1:0] r_pwm_cnt;
  logic [2:0]   r_noc_cnt;
  logic         r_noc1, r_noc2;

  // Phase 1 on counts 0-2, phase 2 on counts 4-6; counts 3 and 7 are dead time.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_pwm_cnt <= '0;
      r_noc_cnt <= '0;
      r_noc1    <= 1'b0;
      r_noc2    <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_noc_cnt <= r_noc_cnt + 1'b1;
      r_noc1    <= (r_noc_cnt < 3'd3);
      r_noc2    <= (r_noc_cnt >= 3'd4) && (r_noc_cnt != 3'd7);
    end
  end

`ifdef UART_TX_EN
  localparam int unsigned BW = $clog2(UART_DIV);

  logic [19:0]   r_tx_shift;
  logic [4:0]    r_tx_bits;
  logic [BW-1:0] r_tx_baud;
  logic          r_tx_busy, r_tx;
  logic [15:0]   w_tx_word;
  logic          w_unused;

  assign w_tx_word = 16'({w_cu, w_upper_nxt});
  assign w_unused  = uart_rx_i;

  // Two 8N1 frames shifted LSB first: high byte, then low byte.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_tx_shift <= '1;
      r_tx_bits  <= '0;
      r_tx_baud  <= '0;
      r_tx_busy  <= 1'b0;
      r_tx       <= 1'b1;
    end else if (!r_tx_busy) begin
      r_tx <= 1'b1;
      if (w_event && w_ctrl) begin
        r_tx_shift <= {1'b1, w_tx_word[7:0], 1'b0, 1'b1, w_tx_word[15:8], 1'b0};
        r_tx_bits  <= '0;
        r_tx_baud  <= '0;
        r_tx_busy  <= 1'b1;
      end
    end else begin
      r_tx <= r_tx_shift[0];
      if (r_tx_baud == BW'(UART_DIV - 1)) begin
        r_tx_baud  <= '0;
        r_tx_shift <= {1'b1, r_tx_shift[19:1]};
        if (r_tx_bits == 5'd19) r_tx_busy <= 1'b0;
        else                    r_tx_bits <= r_tx_bits + 1'b1;
      end else begin
        r_tx_baud <= r_tx_baud + 1'b1;
      end
    end
  end

  assign uart_tx_o = r_tx;
`else
  logic w_unused;
  assign w_unused  = ^{uart_rx_i, w_ctrl};
  assign uart_tx_o = 1'b1;
`endif

  assign dac_upper_o        = r_upper;
  assign dac_lower_o        = r_lower;
  assign dac_wr_upper_o     = r_wr;
  assign dac_wr_lower_o     = r_wr;
  assign dac_pwm_upper_o    = (r_pwm_cnt < r_upper);
  assign dac_pwm_lower_o    = (r_pwm_cnt < r_lower);
  assign overflow_led_o     = r_ovf;
  assign underflow_led_o    = r_unf;
  assign sc_noc_1_o         = r_noc1;
  assign sc_noc_2_o         = r_noc2;
  assign signal_select_en_o = w_enable;
  assign signal_select_in_o = w_sel;
  assign amp_sdn_o          = w_enable;
  assign dac_pd_o           = ~w_enable;
  assign dac_clr_o          = (r_state != ST_IDLE);
  assign idle_led_o         = (r_state == ST_IDLE);
  assign analog_trigger_o   = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign ecg_led_o          = ~(ecg_lod_p_i | ecg_lod_n_i);

endmodule

// File: tb/tb_tbs_core_board.sv
// tb_tbs_core_board: directed table-driven bench for tbs_core_board
// (DEBOUNCE_CYCLES=16, DAC_SETTLING_CLKS=8, defaults otherwise).
module tb_tbs_core_board;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cu = 1'b0, cl = 1'b1, trig = 1'b0;
  logic [5:0] sw_n = 6'b111111;
  logic       lod_p = 1'b0, lod_n = 1'b0, uart_rx = 1'b1;

  logic       sel_en, sel_in, amp_sdn, dac_pd, dac_clr, wr_u, wr_l;
  logic [9:0] up, lo;
  logic       pwm_u, pwm_l, idle, ovf, unf, ecg, atrig, noc1, noc2, tx;

  tbs_core_board #(
    .DAC_BITWIDTH     (10),
    .DAC_SETTLING_CLKS(8),
    .DEBOUNCE_CYCLES  (16),
    .TBS_WINDOW       (16),
    .VIRT_DELTA       (8)
  ) dut (
    .clock_i                 (clk),
    .reset_i                 (rst),
    .comp_upper_i            (cu),
    .comp_lower_i            (cl),
    .trigger_start_sampling_i(trig),
    .trigger_start_mode_i    (sw_n[0]),
    .adaptive_mode_i         (sw_n[1]),
    .control_mode_i          (sw_n[2]),
    .signal_select_in_i      (sw_n[3]),
    .enable_i                (sw_n[4]),
    .select_tbs_delta_steps_i(sw_n[5]),
    .ecg_lod_p_i             (lod_p),
    .ecg_lod_n_i             (lod_n),
    .uart_rx_i               (uart_rx),
    .signal_select_en_o      (sel_en),
    .signal_select_in_o      (sel_in),
    .amp_sdn_o               (amp_sdn),
    .dac_pd_o                (dac_pd),
    .dac_clr_o               (dac_clr),
    .dac_wr_upper_o          (wr_u),
    .dac_wr_lower_o          (wr_l),
    .dac_upper_o             (up),
    .dac_lower_o             (lo),
    .dac_pwm_upper_o         (pwm_u),
    .dac_pwm_lower_o         (pwm_l),
    .idle_led_o              (idle),
    .overflow_led_o          (ovf),
    .underflow_led_o         (unf),
    .ecg_led_o               (ecg),
    .analog_trigger_o        (atrig),
    .sc_noc_1_o              (noc1),
    .sc_noc_2_o              (noc2),
    .uart_tx_o               (tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic sw1;
    logic sw5;
    logic cu;
    logic cl;
    int   n;
    int   up;
    int   lo;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic d, input logic u, input logic l,
                              input int n, input int eu, input int el);
    vec_t v;
    v.sw1 = a; v.sw5 = d; v.cu = u; v.cl = l; v.n = n; v.up = eu; v.lo = el;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [5:0] cfg_n);
    sw_n = cfg_n | 6'b010000;
    rst  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (40) tick();
  endtask

  task automatic wait_idle(input logic want, input string name);
    int k;
    k = 0;
    while (idle !== want && k < 100) begin
      tick();
      k++;
    end
    check(name, int'(idle), int'(want));
  endtask

  task automatic wait_pulse(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (wr_u) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   cyc, cnt_u, cnt_l, ov, rises, k;
    logic p1, p2;

    // Reset state with every switch released.
    do_reset(6'b111111);
    check("rst_idle_led", int'(idle), 1);
    check("rst_upper", int'(up), 528);
    check("rst_lower", int'(lo), 496);
    check("rst_uart_tx", int'(tx), 1);
    check("rst_ovf", int'(ovf), 0);
    check("rst_unf", int'(unf), 0);
    check("rst_wr", int'(wr_u), 0);
    check("rst_dac_clr", int'(dac_clr), 0);
    check("rst_dac_pd", int'(dac_pd), 1);
    check("rst_atrig", int'(atrig), 0);
    for (int i = 0; i < 4; i++) begin
      {lod_p, lod_n} = 2'(i);
      #1;
      check($sformatf("ecg_led_%0d", i), int'(ecg), int'(i == 0));
    end

    // Table: {adaptive, delta, comp_upper, comp_lower, updates, upper, lower}
    vecs[0] = mk(1'b0, 1'b0, 1'b0, 1'b1, 0, 528, 496);
    vecs[1] = mk(1'b0, 1'b0, 1'b1, 1'b1, 3, 531, 499);
    vecs[2] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4, 524, 492);
    vecs[3] = mk(1'b0, 1'b1, 1'b1, 1'b1, 2, 544, 512);
    vecs[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3, 504, 472);
    vecs[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4, 513, 481);
    vecs[6] = mk(1'b1, 1'b0, 1'b1, 1'b1, 5, 559, 527);
    vecs[7] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2, 530, 498);
    vecs[8] = mk(1'b1, 1'b0, 1'b1, 1'b1, 8, 719, 687);
    vecs[9] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2, 525, 493);

    for (int i = 0; i < 10; i++) begin
      cu = vecs[i].cu;
      cl = vecs[i].cl;
      do_reset({~vecs[i].sw5, 1'b1, 1'b1, 1'b1, ~vecs[i].sw1, 1'b1});
      sw_n[4] = 1'b0;
      wait_idle(1'b0, $sformatf("vec%0d_enable", i));
      for (int p = 0; p <= vecs[i].n; p++) begin
        wait_pulse(cyc);
        check($sformatf("vec%0d_pulse%0d", i, p), int'(cyc > 0), 1);
      end
      repeat (2) tick();
      check($sformatf("vec%0d_upper", i), int'(up), vecs[i].up);
      check($sformatf("vec%0d_lower", i), int'(lo), vecs[i].lo);
    end

    // Inside-window run: one write pulse, held thresholds, PWM duty, NOC phases, bounce.
    cu = 1'b0; cl = 1'b1;
    do_reset(6'b111111);
    sw_n[4] = 1'b0;
    wait_idle(1'b0, "win_enable");
    cnt_u = 0; cnt_l = 0;
    for (int j = 0; j < 60; j++) begin
      tick();
      cnt_u += int'(wr_u);
      cnt_l += int'(wr_l);
    end
    check("win_wr_upper_cycles", cnt_u, 1);
    check("win_wr_lower_cycles", cnt_l, 1);
    check("win_upper", int'(up), 528);
    check("win_lower", int'(lo), 496);
    check("win_atrig", int'(atrig), 1);
    check("win_dac_clr", int'(dac_clr), 1);
    check("win_dac_pd", int'(dac_pd), 0);
    check("win_amp_sdn", int'(amp_sdn), 1);
    check("win_sel_en", int'(sel_en), 1);
    cnt_u = 0; cnt_l = 0;
    for (int j = 0; j < 1024; j++) begin
      tick();
      cnt_u += int'(pwm_u);
      cnt_l += int'(pwm_l);
    end
    check("pwm_upper_duty", cnt_u, 528);
    check("pwm_lower_duty", cnt_l, 496);
    ov = 0; rises = 0; p1 = noc1; p2 = noc2;
    for (int j = 0; j < 64; j++) begin
      tick();
      if (noc1 && noc2) ov++;
      if ((p1 && noc2) || (p2 && noc1)) ov++;
      if (noc1 && !p1) rises++;
      p1 = noc1; p2 = noc2;
    end
    check("noc_overlap", ov, 0);
    check("noc1_rises_64", rises, 8);
    sw_n[4] = 1'b1;
    repeat (5) tick();
    sw_n[4] = 1'b0;
    repeat (40) tick();
    check("bounce_not_idle", int'(idle), 0);
    check("bounce_upper", int'(up), 528);
    sw_n[4] = 1'b1;
    wait_idle(1'b1, "disable_to_idle");
    sw_n[3] = 1'b0;
    repeat (30) tick();
    check("sel_in_debounced", int'(sel_in), 1);

    // TBS unit step down to underflow, then forced restart on a delta-switch change.
    cu = 1'b0; cl = 1'b0;
    do_reset(6'b111111);
    sw_n[4] = 1'b0;
    wait_idle(1'b0, "unf_enable");
    wait_pulse(cyc);
    wait_pulse(cyc);
    check("unf_first_lower", int'(lo), 495);
    wait_pulse(cyc);
    check("unf_update_period", cyc, 10);
    k = 0;
    while (!unf && k < 8000) begin
      tick();
      k++;
    end
    check("unf_led", int'(unf), 1);
    check("unf_lower", int'(lo), 0);
    check("unf_upper", int'(up), 32);
    check("unf_no_ovf", int'(ovf), 0);
    repeat (30) tick();
    check("unf_lower_held", int'(lo), 0);
    cl = 1'b1;
    repeat (4) tick();
    sw_n[5] = 1'b0;
    repeat (40) tick();
    check("restart_unf_cleared", int'(unf), 0);
    check("restart_upper", int'(up), 528);
    check("restart_lower", int'(lo), 496);
    check("restart_not_idle", int'(idle), 0);

    // Virtual-resolution step up to overflow.
    cu = 1'b1; cl = 1'b1;
    do_reset(6'b011111);
    sw_n[4] = 1'b0;
    wait_idle(1'b0, "ovf_enable");
    wait_pulse(cyc);
    wait_pulse(cyc);
    check("ovf_first_upper", int'(up), 536);
    k = 0;
    while (!ovf && k < 2000) begin
      tick();
      k++;
    end
    check("ovf_led", int'(ovf), 1);
    check("ovf_upper", int'(up), 1016);
    check("ovf_lower", int'(lo), 984);
    repeat (30) tick();
    check("ovf_upper_held", int'(up), 1016);
    check("ovf_no_unf", int'(unf), 0);

    // ATBS doubling downward, then a direction change restarts at step 1.
    cu = 1'b0; cl = 1'b0;
    do_reset(6'b111101);
    sw_n[4] = 1'b0;
    wait_idle(1'b0, "atbs_enable");
    wait_pulse(cyc);
    wait_pulse(cyc);
    check("atbs_lower_1", int'(lo), 495);
    wait_pulse(cyc);
    check("atbs_lower_2", int'(lo), 493);
    wait_pulse(cyc);
    check("atbs_lower_3", int'(lo), 489);
    wait_pulse(cyc);
    check("atbs_lower_4", int'(lo), 481);
    cu = 1'b1; cl = 1'b1;
    wait_pulse(cyc);
    check("atbs_dirchg_upper", int'(up), 514);
    check("atbs_dirchg_lower", int'(lo), 482);

    // Triggered start: hold in WAIT_TRIG until a trigger rising edge.
    cu = 1'b0; cl = 1'b0; trig = 1'b0;
    do_reset(6'b111110);
    sw_n[4] = 1'b0;
    wait_idle(1'b0, "trig_enable");
    cnt_u = 0;
    for (int j = 0; j < 50; j++) begin
      tick();
      cnt_u += int'(wr_u);
    end
    check("trig_no_pulse", cnt_u, 0);
    check("trig_atrig_low", int'(atrig), 0);
    check("trig_upper", int'(up), 528);
    check("trig_lower", int'(lo), 496);
    trig = 1'b1;
    k = 0;
    while (!atrig && k < 3) begin
      tick();
      k++;
    end
    check("trig_atrig_within_3", int'(atrig), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
